// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format enums, transmitter states and the
// bit-period divider used by both the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push when full and pop when empty
// are ignored; simultaneous push and pop are both honoured.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from a FIFO. Frames are start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits; queued words go out back to back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              data_in,
    input  logic                              valid,
    output logic                              ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int      DIV      = baud_div(CLK_HZ, BAUD);
    localparam int      BW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam parity_e PAR_MODE = parity_e'(PARITY);
    localparam logic    PAR_INV  = (PAR_MODE == ODD);

    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_tx_buffered: illegal parameter combination");
        end
    endgenerate

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 pop, baud_tick;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (valid),
        .wdata_i (data_in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign ready     = !fifo_full;
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign baud_tick = (baud_q == BW'(DIV - 1));

    // Frame sequencing: tx_d is the level for the next bit period, so tx is
    // a pure register. The parity accumulator folds in each data bit as it
    // is launched, so it is complete when the last data bit ends.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q == ST_IDLE) begin
            baud_d = '0;
            bit_d  = '0;
            tx_d   = 1'b1;
            if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = fifo_rdata;
                state_d = ST_START;
                tx_d    = 1'b0;
            end
        end else begin
            baud_d = baud_q + 1'b1;
            if (baud_tick) begin
                baud_d = '0;
                unique case (state_q)
                    ST_START: begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                        par_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                    ST_DATA: begin
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_d = '0;
                            if (PAR_MODE != NONE) begin
                                state_d = ST_PARITY;
                                tx_d    = par_q ^ PAR_INV;
                            end else begin
                                state_d = ST_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            tx_d    = shift_q[0];
                            par_d   = par_q ^ shift_q[0];
                            shift_d = shift_q >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state_d = ST_STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end
                    ST_STOP: begin
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            bit_d = '0;
                            // Chain straight into the next start bit when work is queued.
                            if (!fifo_empty) begin
                                pop     = 1'b1;
                                shift_d = fifo_rdata;
                                state_d = ST_START;
                                tx_d    = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                endcase
            end
        end
    end

    // State and datapath registers; reset truncates any frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
